// File: rtl/tl_pkg.sv
// Shared encodings for the intersection controller: mode codes, head colours and
// signal phases, plus small helpers for phase order and head colour decode.
package tl_pkg;

    localparam logic [3:0] MODE_OFF   = 4'd0;
    localparam logic [3:0] MODE_INIT  = 4'd1;
    localparam logic [3:0] MODE_ORD   = 4'd2;
    localparam logic [3:0] MODE_BUSY  = 4'd3;
    localparam logic [3:0] MODE_NIGHT = 4'd4;
    localparam logic [3:0] MODE_PAUSE = 4'd5;
    localparam logic [3:0] MODE_LINE  = 4'd6;

    // Head colours are {R,Y,G}.
    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [1:0] {
        MG = 2'd0,
        MY = 2'd1,
        SG = 2'd2,
        SY = 2'd3
    } phase_e;

    function automatic phase_e nextPhase(input phase_e p);
        phase_e n;
        case (p)
            MG:      n = MY;
            MY:      n = SG;
            SG:      n = SY;
            default: n = MG;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] mainColour(input phase_e p);
        logic [2:0] c;
        case (p)
            MG:      c = GRN;
            MY:      c = YEL;
            default: c = RED;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] subColour(input phase_e p);
        logic [2:0] c;
        case (p)
            SG:      c = GRN;
            SY:      c = YEL;
            default: c = RED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one signal phase; expire marks the tick
// on which the running phase ends.
module phase_timer #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    input  logic          clr,
    output logic [TW-1:0] count,
    output logic          expire
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // The count never drops below 1 on its own; the owner reloads it on expire.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q > TW'(1))) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = en && (count_q == TW'(1));

endmodule

// File: rtl/phase_sequencer.sv
// Sequences the main/sub signal heads through MG->MY->SG->SY under the mode
// selected by the controller and reports per-head remaining time.
module phase_sequencer
    import tl_pkg::*;
#(
    parameter int ORD_MG  = 20,
    parameter int ORD_SG  = 15,
    parameter int BUSY_MG = 30,
    parameter int BUSY_SG = 10,
    parameter int YEL_T   = 3,
    parameter int TW      = 6
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          tick,
    input  logic [3:0]    mode,
    output logic [2:0]    main_light,
    output logic [2:0]    sub_light,
    output logic [TW-1:0] main_rest,
    output logic [TW-1:0] sub_rest,
    output logic [1:0]    phase,
    output logic          phase_end
);

    localparam logic [TW-1:0] ORD_MG_W  = TW'(ORD_MG);
    localparam logic [TW-1:0] ORD_SG_W  = TW'(ORD_SG);
    localparam logic [TW-1:0] BUSY_MG_W = TW'(BUSY_MG);
    localparam logic [TW-1:0] BUSY_SG_W = TW'(BUSY_SG);
    localparam logic [TW-1:0] YEL_W     = TW'(YEL_T);

    localparam int MAX_MG    = (ORD_MG > BUSY_MG) ? ORD_MG : BUSY_MG;
    localparam int MAX_SG    = (ORD_SG > BUSY_SG) ? ORD_SG : BUSY_SG;
    localparam int MAX_GREEN = (MAX_MG > MAX_SG) ? MAX_MG : MAX_SG;

    if (MAX_GREEN + YEL_T >= (1 << TW)) begin : g_width_check
        $error("phase_sequencer: longest green plus YEL_T does not fit in TW bits");
    end

    phase_e        phase_q,     phase_d;
    logic          blink_q,     blink_d;
    logic [2:0]    mainLight_q, mainLight_d;
    logic [2:0]    subLight_q,  subLight_d;
    logic [TW-1:0] mainRest_q,  mainRest_d;
    logic [TW-1:0] subRest_q,   subRest_d;
    logic          phaseEnd_q,  phaseEnd_d;

    logic          timerLoad;
    logic [TW-1:0] timerLoadVal;
    logic          timerEn;
    logic          timerClr;
    logic [TW-1:0] timerCount;
    logic          timerExpire;
    logic [TW-1:0] timerNext;
    logic          running;
    logic          busyPlan;

    assign running  = (mode == MODE_ORD) || (mode == MODE_BUSY);
    assign busyPlan = (mode == MODE_BUSY);
    assign timerEn  = running && tick;

    function automatic logic [TW-1:0] phaseDuration(input phase_e p, input logic busy);
        logic [TW-1:0] d;
        case (p)
            MG:      d = busy ? BUSY_MG_W : ORD_MG_W;
            SG:      d = busy ? BUSY_SG_W : ORD_SG_W;
            default: d = YEL_W;
        endcase
        return d;
    endfunction

    // A head that stays red through the other road's yellow waits that yellow too.
    function automatic logic [TW-1:0] mainRestOf(input phase_e p, input logic [TW-1:0] t);
        return (p == SG) ? t + YEL_W : t;
    endfunction

    function automatic logic [TW-1:0] subRestOf(input phase_e p, input logic [TW-1:0] t);
        return (p == MG) ? t + YEL_W : t;
    endfunction

    phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .Reset    (Reset),
        .load     (timerLoad),
        .load_val (timerLoadVal),
        .en       (timerEn),
        .clr      (timerClr),
        .count    (timerCount),
        .expire   (timerExpire)
    );

    always_comb begin
        phase_d      = phase_q;
        blink_d      = blink_q;
        mainLight_d  = mainLight_q;
        subLight_d   = subLight_q;
        mainRest_d   = mainRest_q;
        subRest_d    = subRest_q;
        phaseEnd_d   = 1'b0;
        timerLoad    = 1'b0;
        timerLoadVal = '0;
        timerClr     = 1'b0;
        timerNext    = timerCount;

        case (mode)
            MODE_INIT: begin
                phase_d      = MG;
                timerLoad    = 1'b1;
                timerLoadVal = ORD_MG_W;
                timerNext    = ORD_MG_W;
                mainLight_d  = mainColour(MG);
                subLight_d   = subColour(MG);
                mainRest_d   = mainRestOf(MG, ORD_MG_W);
                subRest_d    = subRestOf(MG, ORD_MG_W);
            end
            MODE_ORD, MODE_BUSY: begin
                // An empty timer means we just arrived from a stopped mode: start MG fresh.
                if (timerCount == '0) begin
                    phase_d      = MG;
                    timerLoad    = 1'b1;
                    timerLoadVal = phaseDuration(MG, busyPlan);
                    timerNext    = timerLoadVal;
                end else if (timerExpire) begin
                    phase_d      = nextPhase(phase_q);
                    timerLoad    = 1'b1;
                    timerLoadVal = phaseDuration(nextPhase(phase_q), busyPlan);
                    timerNext    = timerLoadVal;
                    phaseEnd_d   = 1'b1;
                end else if (tick) begin
                    timerNext = timerCount - TW'(1);
                end
                mainLight_d = mainColour(phase_d);
                subLight_d  = subColour(phase_d);
                mainRest_d  = mainRestOf(phase_d, timerNext);
                subRest_d   = subRestOf(phase_d, timerNext);
            end
            MODE_NIGHT: begin
                phase_d     = MG;
                timerClr    = 1'b1;
                timerNext   = '0;
                blink_d     = blink_q ^ tick;
                mainLight_d = blink_d ? YEL : DARK;
                subLight_d  = blink_d ? YEL : DARK;
                mainRest_d  = '0;
                subRest_d   = '0;
            end
            MODE_PAUSE: begin
            end
            MODE_LINE: begin
                phase_d     = MG;
                timerClr    = 1'b1;
                timerNext   = '0;
                mainLight_d = GRN;
                subLight_d  = RED;
                mainRest_d  = '0;
                subRest_d   = '0;
            end
            default: begin
                phase_d     = MG;
                timerClr    = 1'b1;
                timerNext   = '0;
                blink_d     = 1'b0;
                mainLight_d = DARK;
                subLight_d  = DARK;
                mainRest_d  = '0;
                subRest_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            phase_q     <= MG;
            blink_q     <= 1'b0;
            mainLight_q <= DARK;
            subLight_q  <= DARK;
            mainRest_q  <= '0;
            subRest_q   <= '0;
            phaseEnd_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            mainLight_q <= mainLight_d;
            subLight_q  <= subLight_d;
            mainRest_q  <= mainRest_d;
            subRest_q   <= subRest_d;
            phaseEnd_q  <= phaseEnd_d;
        end
    end

    assign main_light = mainLight_q;
    assign sub_light  = subLight_q;
    assign main_rest  = mainRest_q;
    assign sub_rest   = subRest_q;
    assign phase      = phase_q;
    assign phase_end  = phaseEnd_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: fixed vectors, hand-written corner sequences and
// random mode/tick traffic compared against a phase-table reference model.
module tb_phase_sequencer;

    localparam int ORD_MG  = 20;
    localparam int ORD_SG  = 15;
    localparam int BUSY_MG = 30;
    localparam int BUSY_SG = 10;
    localparam int YEL_T   = 3;
    localparam int TW      = 6;

    logic          clk;
    logic          Reset;
    logic          tick;
    logic [3:0]    mode;
    logic [2:0]    main_light;
    logic [2:0]    sub_light;
    logic [TW-1:0] main_rest;
    logic [TW-1:0] sub_rest;
    logic [1:0]    phase;
    logic          phase_end;

    int checks;
    int errors;

    phase_sequencer #(
        .ORD_MG(ORD_MG), .ORD_SG(ORD_SG), .BUSY_MG(BUSY_MG),
        .BUSY_SG(BUSY_SG), .YEL_T(YEL_T), .TW(TW)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .tick       (tick),
        .mode       (mode),
        .main_light (main_light),
        .sub_light  (sub_light),
        .main_rest  (main_rest),
        .sub_rest   (sub_rest),
        .phase      (phase),
        .phase_end  (phase_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase index 0..3 = MG,MY,SG,SY; plan 0 = normal, 1 = peak.
    int m_phase, m_t, m_plan, m_ml, m_sl, m_mr, m_sr, m_pe;
    bit m_blink;

    function automatic int durOf(input int plan, input int ph);
        if (ph == 0) return (plan != 0) ? BUSY_MG : ORD_MG;
        if (ph == 2) return (plan != 0) ? BUSY_SG : ORD_SG;
        return YEL_T;
    endfunction

    function automatic int colourOf(input int head, input int ph);
        int green_ph = (head == 0) ? 0 : 2;
        if (ph == green_ph) return 1;
        if (ph == green_ph + 1) return 2;
        return 4;
    endfunction

    // Ticks until a head changes colour: the running phase plus every following
    // phase in which that head keeps the same colour.
    function automatic int restOf(input int head);
        int r = m_t;
        int p = (m_phase + 1) % 4;
        while (colourOf(head, p) == colourOf(head, m_phase)) begin
            r += durOf(m_plan, p);
            p = (p + 1) % 4;
        end
        return r % (1 << TW);
    endfunction

    task automatic modelReset();
        m_phase = 0; m_t = 0; m_plan = 0; m_blink = 0;
        m_ml = 0; m_sl = 0; m_mr = 0; m_sr = 0; m_pe = 0;
    endtask

    task automatic showRunning();
        m_ml = colourOf(0, m_phase);
        m_sl = colourOf(1, m_phase);
        m_mr = restOf(0);
        m_sr = restOf(1);
    endtask

    task automatic modelStep(input logic [3:0] md, input logic tk);
        m_pe = 0;
        case (md)
            4'd1: begin
                m_phase = 0; m_t = ORD_MG; m_plan = 0;
                showRunning();
            end
            4'd2, 4'd3: begin
                m_plan = (md == 4'd3) ? 1 : 0;
                if (m_t == 0) begin
                    m_phase = 0; m_t = durOf(m_plan, 0);
                end else if (tk) begin
                    if (m_t == 1) begin
                        m_phase = (m_phase + 1) % 4;
                        m_t = durOf(m_plan, m_phase);
                        m_pe = 1;
                    end else begin
                        m_t = m_t - 1;
                    end
                end
                showRunning();
            end
            4'd4: begin
                m_phase = 0; m_t = 0;
                if (tk) m_blink = !m_blink;
                m_ml = m_blink ? 2 : 0; m_sl = m_ml; m_mr = 0; m_sr = 0;
            end
            4'd5: begin
            end
            4'd6: begin
                m_phase = 0; m_t = 0; m_ml = 1; m_sl = 4; m_mr = 0; m_sr = 0;
            end
            default: begin
                modelReset();
            end
        endcase
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".main_light"}, int'(main_light), m_ml);
        checkValue({tag, ".sub_light"},  int'(sub_light),  m_sl);
        checkValue({tag, ".main_rest"},  int'(main_rest),  m_mr);
        checkValue({tag, ".sub_rest"},   int'(sub_rest),   m_sr);
        checkValue({tag, ".phase"},      int'(phase),      m_phase);
        checkValue({tag, ".phase_end"},  int'(phase_end),  m_pe);
    endtask

    task automatic applyStimulus(input logic [3:0] md, input logic tk);
        mode = md;
        tick = tk;
        @(posedge clk);
        #1;
        modelStep(md, tk);
    endtask

    typedef struct {
        string      name;
        logic [3:0] md;
        logic       tk;
        int         eMain, eSub, eMr, eSr, ePh, ePe;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input string name, input logic [3:0] md, input logic tk,
                          input int eMain, input int eSub, input int eMr,
                          input int eSr, input int ePh, input int ePe);
        vec_t v;
        v.name = name; v.md = md; v.tk = tk;
        v.eMain = eMain; v.eSub = eSub; v.eMr = eMr; v.eSr = eSr;
        v.ePh = ePh; v.ePe = ePe;
        vecs.push_back(v);
    endtask

    int         peCount;
    int         r;
    int         dwell;
    logic [3:0] rmd;

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        mode   = 4'd0;
        tick   = 1'b0;
        modelReset();

        addVec("v_init",        4'd1, 1'b0, 1, 4, 20, 23, 0, 0);
        addVec("v_init_tick",   4'd1, 1'b1, 1, 4, 20, 23, 0, 0);
        addVec("v_init_tick2",  4'd1, 1'b1, 1, 4, 20, 23, 0, 0);
        addVec("v_ord_idle",    4'd2, 1'b0, 1, 4, 20, 23, 0, 0);
        addVec("v_ord_t1",      4'd2, 1'b1, 1, 4, 19, 22, 0, 0);
        addVec("v_ord_t2",      4'd2, 1'b1, 1, 4, 18, 21, 0, 0);
        addVec("v_busy_t",      4'd3, 1'b1, 1, 4, 17, 20, 0, 0);
        addVec("v_pause",       4'd5, 1'b1, 1, 4, 17, 20, 0, 0);
        addVec("v_ord_resume",  4'd2, 1'b0, 1, 4, 17, 20, 0, 0);
        addVec("v_line",        4'd6, 1'b1, 1, 4, 0,  0,  0, 0);
        addVec("v_ord_reload",  4'd2, 1'b1, 1, 4, 20, 23, 0, 0);
        addVec("v_night_on",    4'd4, 1'b1, 2, 2, 0,  0,  0, 0);
        addVec("v_night_hold",  4'd4, 1'b0, 2, 2, 0,  0,  0, 0);
        addVec("v_night_off",   4'd4, 1'b1, 0, 0, 0,  0,  0, 0);
        addVec("v_code9",       4'd9, 1'b1, 0, 0, 0,  0,  0, 0);
        addVec("v_busy_load",   4'd3, 1'b0, 1, 4, 30, 33, 0, 0);
        addVec("v_code15",      4'd15, 1'b0, 0, 0, 0, 0,  0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkValue("reset.main_light", int'(main_light), 0);
        checkValue("reset.sub_light",  int'(sub_light),  0);
        checkValue("reset.main_rest",  int'(main_rest),  0);
        checkValue("reset.sub_rest",   int'(sub_rest),   0);
        checkValue("reset.phase",      int'(phase),      0);
        checkValue("reset.phase_end",  int'(phase_end),  0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].md, vecs[i].tk);
            checkValue({vecs[i].name, ".main_light"}, int'(main_light), vecs[i].eMain);
            checkValue({vecs[i].name, ".sub_light"},  int'(sub_light),  vecs[i].eSub);
            checkValue({vecs[i].name, ".main_rest"},  int'(main_rest),  vecs[i].eMr);
            checkValue({vecs[i].name, ".sub_rest"},   int'(sub_rest),   vecs[i].eSr);
            checkValue({vecs[i].name, ".phase"},      int'(phase),      vecs[i].ePh);
            checkValue({vecs[i].name, ".phase_end"},  int'(phase_end),  vecs[i].ePe);
        end

        // Full MG in the normal plan: exactly one phase_end, on the 20th tick.
        applyStimulus(4'd1, 1'b0);
        checkOutput("A.init");
        peCount = 0;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(4'd2, 1'b1);
            checkOutput("A.tick");
            if (phase_end) peCount++;
            if (i < 20) begin
                applyStimulus(4'd2, 1'b0);
                if (phase_end) peCount++;
            end
        end
        checkValue("A.pe_count",   peCount, 1);
        checkValue("A.my_phase",   int'(phase), 1);
        checkValue("A.my_main",    int'(main_light), 2);
        checkValue("A.my_mrest",   int'(main_rest), 3);
        checkValue("A.my_srest",   int'(sub_rest), 3);
        checkValue("A.my_pe",      int'(phase_end), 1);
        applyStimulus(4'd2, 1'b0);
        checkValue("A.pe_single",  int'(phase_end), 0);
        repeat (3) applyStimulus(4'd2, 1'b1);
        checkValue("A.sg_phase",   int'(phase), 2);
        checkValue("A.sg_sub",     int'(sub_light), 1);
        checkValue("A.sg_main",    int'(main_light), 4);
        checkValue("A.sg_srest",   int'(sub_rest), 15);
        checkValue("A.sg_mrest",   int'(main_rest), 18);

        // Plan switch mid-MG must not truncate; next SG comes from the peak plan.
        applyStimulus(4'd6, 1'b0);
        applyStimulus(4'd2, 1'b0);
        checkValue("B.fresh_mg", int'(main_rest), 20);
        repeat (13) applyStimulus(4'd2, 1'b1);
        checkValue("B.t7", int'(main_rest), 7);
        repeat (6) begin
            applyStimulus(4'd3, 1'b1);
            checkOutput("B.busy_mg");
        end
        checkValue("B.t1_phase", int'(phase), 0);
        checkValue("B.t1_rest",  int'(main_rest), 1);
        applyStimulus(4'd3, 1'b1);
        checkValue("B.my_phase", int'(phase), 1);
        checkValue("B.my_rest",  int'(main_rest), 3);
        repeat (3) applyStimulus(4'd3, 1'b1);
        checkValue("B.sg_phase", int'(phase), 2);
        checkValue("B.sg_srest", int'(sub_rest), 10);
        checkValue("B.sg_mrest", int'(main_rest), 13);

        // PAUSE freezes SG at t=9 despite ticks.
        applyStimulus(4'd2, 1'b1);
        checkValue("C.sg9", int'(sub_rest), 9);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(4'd5, 1'b1);
            checkOutput("C.pause");
        end
        checkValue("C.frozen_srest", int'(sub_rest), 9);
        checkValue("C.frozen_mrest", int'(main_rest), 12);
        checkValue("C.frozen_sub",   int'(sub_light), 1);
        applyStimulus(4'd2, 1'b0);
        checkValue("C.resume_srest", int'(sub_rest), 9);
        applyStimulus(4'd2, 1'b1);
        checkValue("C.tick_srest", int'(sub_rest), 8);
        checkValue("C.tick_mrest", int'(main_rest), 11);

        // LINE mid-SY, then an undefined code, then reset mid-MY without a clock edge.
        repeat (7) applyStimulus(4'd2, 1'b1);
        applyStimulus(4'd2, 1'b1);
        checkValue("D.sy_phase", int'(phase), 3);
        checkValue("D.sy_sub",   int'(sub_light), 2);
        checkValue("D.sy_main",  int'(main_light), 4);
        applyStimulus(4'd2, 1'b1);
        checkOutput("D.sy2");
        applyStimulus(4'd6, 1'b0);
        checkValue("D.line_main",  int'(main_light), 1);
        checkValue("D.line_sub",   int'(sub_light), 4);
        checkValue("D.line_mrest", int'(main_rest), 0);
        checkValue("D.line_srest", int'(sub_rest), 0);
        applyStimulus(4'd9, 1'b1);
        checkOutput("D.code9");

        applyStimulus(4'd2, 1'b0);
        repeat (21) applyStimulus(4'd2, 1'b1);
        checkValue("E.my_phase", int'(phase), 1);
        checkValue("E.my_rest",  int'(main_rest), 2);
        #2;
        Reset = 1'b1;
        #1;
        checkValue("E.async_main",  int'(main_light), 0);
        checkValue("E.async_sub",   int'(sub_light), 0);
        checkValue("E.async_mrest", int'(main_rest), 0);
        checkValue("E.async_srest", int'(sub_rest), 0);
        checkValue("E.async_phase", int'(phase), 0);
        mode = 4'd0;
        tick = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        Reset = 1'b0;
        applyStimulus(4'd2, 1'b0);
        checkOutput("E.after_reset");

        // Random mode dwells with random ticks against the model.
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 15);
            if (r <= 4 || r == 15) rmd = 4'd2;
            else if (r <= 8)       rmd = 4'd3;
            else if (r == 9)       rmd = 4'd1;
            else if (r == 10)      rmd = 4'd4;
            else if (r == 11)      rmd = 4'd5;
            else if (r == 12)      rmd = 4'd6;
            else if (r == 13)      rmd = 4'd0;
            else                   rmd = 4'($urandom_range(7, 15));
            dwell = $urandom_range(1, 120);
            for (int c = 0; c < dwell; c++) begin
                applyStimulus(rmd, ($urandom_range(0, 1) == 1));
                checkOutput("rand");
            end
        end

        tick = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Responder end of the intersection mode-command interface. The mode controller drives a 4-bit mode code; this block sequences the main/sub signal heads through their colour phases and produces the per-road remaining-time values for the display path. It owns all phase timing. The controller only selects which mode applies.

## Interface
Parameters:
- ORD_MG, 20, main-green duration in ticks, normal plan
- ORD_SG, 15, sub-green duration in ticks, normal plan
- BUSY_MG, 30, main-green duration in ticks, peak plan
- BUSY_SG, 10, sub-green duration in ticks, peak plan
- YEL_T, 3, yellow duration in ticks, both plans
- TW, 6, width of the timer and remaining-time outputs

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse, 1 per second, from the clock divider
- mode  in  4  mode code: OFF=0, INIT=1, ORD=2, BUSY=3, NIGHT=4, PAUSE=5, LINE=6. Codes 7–15 behave as OFF.
- main_light  out  3  {R,Y,G}: red=100, yellow=010, green=001, dark=000
- sub_light  out  3  same encoding as main_light
- main_rest  out  TW  ticks until the main head changes colour
- sub_rest  out  TW  ticks until the sub head changes colour
- phase  out  2  MG=0, MY=1, SG=2, SY=3
- phase_end  out  1  one-cycle pulse on each phase advance

## Operation
Reset values: lights 000, rests 0, phase MG, timer 0, blink 0, phase_end 0. All outputs are registered.

Phases and head colours:
- MG: main green, sub red. Duration is the plan's MG value.
- MY: main yellow, sub red. Duration YEL_T.
- SG: main red, sub green. Duration is the plan's SG value.
- SY: main red, sub yellow. Duration YEL_T.
- Sequence: MG→MY→SG→SY→MG.

Timer rule, applied in ORD or BUSY on a cycle where tick=1:
- timer>1: decrement the timer.
- timer==1: advance the phase, load the next phase's duration, pulse phase_end.
- Each phase therefore lasts exactly D ticks.
- The plan (ORD or BUSY) is sampled only when a duration is loaded. Switching between ORD and BUSY never truncates the running phase.

Remaining-time outputs:
- MG: main_rest=t, sub_rest=t+YEL_T.
- SG: sub_rest=t, main_rest=t+YEL_T.
- MY, SY: both rests equal t.
- Sums are TW bits. Parameters must satisfy max(MG,SG)+YEL_T < 2^TW, checked by an elaboration assertion.

Per-mode behaviour, evaluated on the current cycle's mode:
- OFF (and codes 7–15): lights 000, rests 0, phase MG, timer 0, blink 0.
- INIT: phase MG, timer loaded with ORD_MG, lights set to MG colours, rests as above. Holds, ignoring tick.
- ORD / BUSY: run the timer rule.
  - If timer==0 on entry (arriving from OFF, NIGHT or LINE), load the MG duration of the current plan on that cycle. No tick is consumed.
- NIGHT:
  - Both heads show 010 when blink=1 and 000 when blink=0.
  - blink toggles on each tick.
  - Rests are 0 and the timer is cleared to 0.
- PAUSE: freeze all state and outputs. tick is ignored. Leaving PAUSE resumes from the same phase and timer value.
- LINE:
  - Main head 001, sub head 100, rests 0, timer cleared to 0, phase MG.
  - Leaving LINE to ORD or BUSY restarts MG with a fresh load.

Boundary cases:
- tick in the same cycle as a mode change: the new mode's rule applies; a tick is ignored in non-running modes.
- phase_end never asserts outside ORD/BUSY.
- Reset asserted mid-phase returns all state to reset values immediately (asynchronous).

## Timing
- Mode change to output change: 1 clk.
- tick to decremented rest: 1 clk.
- Phase advance: the lights, the new rests and phase_end all appear on the same edge.
- Minimum mode dwell: 1 clk. No mode handshake; the controller holds the level.

## Structure
- Shared package tl_pkg holds:
  - mode constants (OFF…LINE), matching the controller's encoding
  - light encodings RED/YEL/GRN/DARK
  - phase encodings MG/MY/SG/SY
- Sub-module phase_timer is a TW-bit loadable down-counter.
  - Inputs: load, load_val, en (tick), clr.
  - Outputs: count, expire (count==1 and en).
- Top level: phase register, plan select, colour decode, rest arithmetic, blink flop.

## Test plan
- Reset, then mode=INIT: main 001, sub 100, main_rest 20, sub_rest 23; 5 ticks produce no change.
- mode=ORD, 20 ticks: phase_end is a single pulse on the 20th tick; phase MY, main 010, rests 3/3; after 3 more ticks phase SG, sub_rest 15, main_rest 18.
- In ORD at MG with t=7, switch to BUSY: MG finishes its 7 ticks, the MY/SY durations stay 3, and SG loads 10.
- PAUSE at SG with t=9 for 50 ticks: all outputs frozen; return to ORD and SG continues from 9.
- NIGHT with 4 ticks: both heads toggle 010/000/010/000, rests 0; mode=ORD then loads ORD_MG=20 at MG with no tick consumed.
- LINE asserted mid-SY: main 001, sub 100, rests 0 on the next clk; mode=9 gives all outputs dark and 0; Reset asserted mid-MY clears everything without a clk edge.
